// File: rtl/countdown_timer_mmss_if.sv
// Control and display signal bundle for the MM:SS countdown timer.
interface countdown_timer_mmss_if;
    logic       Tick;
    logic       LD;
    logic [2:0] IN_MIN_T;
    logic [3:0] IN_MIN_U;
    logic [2:0] IN_SEC_T;
    logic [3:0] IN_SEC_U;
    logic       Start;
    logic       Pause;
    logic       Ack;
    logic [2:0] MIN_T;
    logic [3:0] MIN_U;
    logic [2:0] SEC_T;
    logic [3:0] SEC_U;
    logic       RUNNING;
    logic       DONE;
    logic       ALARM;

    modport master (
        output Tick, LD, IN_MIN_T, IN_MIN_U, IN_SEC_T, IN_SEC_U,
        output Start, Pause, Ack,
        input  MIN_T, MIN_U, SEC_T, SEC_U, RUNNING, DONE, ALARM
    );

    modport slave (
        input  Tick, LD, IN_MIN_T, IN_MIN_U, IN_SEC_T, IN_SEC_U,
        input  Start, Pause, Ack,
        output MIN_T, MIN_U, SEC_T, SEC_U, RUNNING, DONE, ALARM
    );
endinterface

// File: rtl/countdown_timer_mmss.sv
// Four-digit BCD MM:SS down-counter with load, start/pause and a
// self-clearing alarm that rings for a bounded number of ticks.
module countdown_timer_mmss #(
    parameter int ALARM_HOLD_SEC = 60
) (
    input  logic                   Clk,
    input  logic                   Clr,
    countdown_timer_mmss_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] PAUSED  = 2'd2;
    localparam logic [1:0] RINGING = 2'd3;
    localparam logic [7:0] HOLD    = 8'(ALARM_HOLD_SEC);

    logic [1:0] r_state;
    logic [2:0] r_min_t;
    logic [3:0] r_min_u;
    logic [2:0] r_sec_t;
    logic [3:0] r_sec_u;
    logic [7:0] r_ring;
    logic       r_running;
    logic       r_done;
    logic       r_alarm;

    logic       w_zero;
    logic       w_one;
    logic       w_ld_ok;
    logic [2:0] w_nmt;
    logic [3:0] w_nmu;
    logic [2:0] w_nst;
    logic [3:0] w_nsu;

    assign w_zero = (r_min_t == 3'd0) && (r_min_u == 4'd0) &&
                    (r_sec_t == 3'd0) && (r_sec_u == 4'd0);
    assign w_one  = (r_min_t == 3'd0) && (r_min_u == 4'd0) &&
                    (r_sec_t == 3'd0) && (r_sec_u == 4'd1);
    assign w_ld_ok = (bus.IN_MIN_T <= 3'd5) && (bus.IN_MIN_U <= 4'd9) &&
                     (bus.IN_SEC_T <= 3'd5) && (bus.IN_SEC_U <= 4'd9);

    // One BCD borrow chain; only used while the count is non-zero.
    always_comb begin
        w_nsu = r_sec_u - 4'd1;
        w_nst = r_sec_t;
        w_nmu = r_min_u;
        w_nmt = r_min_t;
        if (r_sec_u == 4'd0) begin
            w_nsu = 4'd9;
            w_nst = r_sec_t - 3'd1;
            if (r_sec_t == 3'd0) begin
                w_nst = 3'd5;
                w_nmu = r_min_u - 4'd1;
                if (r_min_u == 4'd0) begin
                    w_nmu = 4'd9;
                    w_nmt = r_min_t - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state   <= IDLE;
            r_min_t   <= 3'd0;
            r_min_u   <= 4'd0;
            r_sec_t   <= 3'd0;
            r_sec_u   <= 4'd0;
            r_ring    <= 8'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, PAUSED: begin
                    if (bus.LD && w_ld_ok) begin
                        r_min_t <= bus.IN_MIN_T;
                        r_min_u <= bus.IN_MIN_U;
                        r_sec_t <= bus.IN_SEC_T;
                        r_sec_u <= bus.IN_SEC_U;
                    end
                    // Start sees the pre-load count; Pause blocks resume.
                    if (bus.Start && !w_zero &&
                        !(r_state == PAUSED && bus.Pause)) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.Pause) begin
                        r_state   <= PAUSED;
                        r_running <= 1'b0;
                    end else if (bus.Tick) begin
                        if (w_one) begin
                            r_sec_u   <= 4'd0;
                            r_state   <= RINGING;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                            r_alarm   <= 1'b1;
                            r_ring    <= 8'd0;
                        end else begin
                            r_min_t <= w_nmt;
                            r_min_u <= w_nmu;
                            r_sec_t <= w_nst;
                            r_sec_u <= w_nsu;
                        end
                    end
                end
                default: begin
                    if (bus.Ack || (bus.Tick && (r_ring + 8'd1 == HOLD))) begin
                        r_state <= IDLE;
                        r_alarm <= 1'b0;
                        r_ring  <= 8'd0;
                    end else if (bus.Tick) begin
                        r_ring <= r_ring + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.MIN_T   = r_min_t;
    assign bus.MIN_U   = r_min_u;
    assign bus.SEC_T   = r_sec_t;
    assign bus.SEC_U   = r_sec_u;
    assign bus.RUNNING = r_running;
    assign bus.DONE    = r_done;
    assign bus.ALARM   = r_alarm;
endmodule
